// File: rtl/prbs_pkg.sv
// rtl/prbs_pkg.sv - shared PRBS-9 constants, checker state type and byte popcount
package prbs_pkg;

   localparam int PRBS9_TAP_HI = 8;
   localparam int PRBS9_TAP_LO = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEED   = 2'd1,
      CHECK  = 2'd2,
      LOCKED = 2'd3
   } prbs_chk_state_t;

   function automatic logic [3:0] prbs9_popcount8(input logic [7:0] b);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'b000, b[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/prbs_9_checker_if.sv
// rtl/prbs_9_checker_if.sv - received byte stream from the deserializer
interface prbs_9_checker_if;

   logic       Data_Valid;
   logic [7:0] Data_In;

   modport master (
      output Data_Valid,
      output Data_In
   );

   modport slave (
      input Data_Valid,
      input Data_In
   );

endinterface

// File: rtl/prbs9_byte_step.sv
// rtl/prbs9_byte_step.sv - eight unrolled x^9+x^5+1 steps; first generated bit lands in bit 7
module prbs9_byte_step
   import prbs_pkg::*;
(
   input  logic [8:0] State,
   output logic [7:0] Pred_Byte,
   output logic [8:0] Next_State
);

   always_comb begin
      logic [8:0] s;
      logic       nb;
      s         = State;
      nb        = 1'b0;
      Pred_Byte = 8'd0;
      for (int i = 0; i < 8; i++) begin
         nb             = s[PRBS9_TAP_HI] ^ s[PRBS9_TAP_LO];
         Pred_Byte[7-i] = nb;
         s              = {s[7:0], nb};
      end
      Next_State = s;
   end

endmodule

// File: rtl/prbs_9_checker.sv
// rtl/prbs_9_checker.sv - self-synchronising PRBS-9 byte checker; PRBS_CHK_ERR_CNT_EN builds the bit-error counter
module prbs_9_checker
   import prbs_pkg::*;
#(
   parameter int LOCK_CNT = 4,
   parameter int LOSS_CNT = 3,
   parameter int COUNT_W  = 16
) (
   input  logic                  Clk,
   input  logic                  RxRst,
   input  logic                  Enable,
   prbs_9_checker_if.slave       Rx,
   input  logic                  Clear_Count,
   output logic                  Locked,
   output logic                  Err_Flag,
   output logic                  Sync_Lost,
   output logic [COUNT_W-1:0]    Err_Count
);

   localparam int MC_W = $clog2(LOCK_CNT + 1);
   localparam int BC_W = $clog2(LOSS_CNT + 1);

   prbs_chk_state_t state;
   logic [8:0]      lfsr;
   logic [8:0]      next_lfsr;
   logic [7:0]      pred_byte;
   logic            seed_phase;
   logic            seed_bit;
   logic [MC_W-1:0] match_cnt;
   logic [BC_W-1:0] bad_cnt;
   logic            byte_err;
   logic            lock_err;

   prbs9_byte_step u_step (
      .State      (lfsr),
      .Pred_Byte  (pred_byte),
      .Next_State (next_lfsr)
   );

   assign byte_err = (Rx.Data_In != pred_byte);
   assign lock_err = Enable && Rx.Data_Valid && (state == LOCKED) && byte_err;

   always_ff @(posedge Clk) begin
      if (RxRst) begin
         state      <= IDLE;
         lfsr       <= 9'd0;
         seed_phase <= 1'b0;
         seed_bit   <= 1'b0;
         match_cnt  <= '0;
         bad_cnt    <= '0;
         Locked     <= 1'b0;
         Err_Flag   <= 1'b0;
         Sync_Lost  <= 1'b0;
      end else begin
         Err_Flag  <= 1'b0;
         Sync_Lost <= 1'b0;
         if (!Enable) begin
            state  <= IDLE;
            Locked <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  state      <= SEED;
                  seed_phase <= 1'b0;
               end
               SEED: begin
                  if (Rx.Data_Valid) begin
                     if (!seed_phase) begin
                        seed_bit   <= Rx.Data_In[0];
                        seed_phase <= 1'b1;
                     end else begin
                        // last nine received bits become the predictor state
                        lfsr       <= {seed_bit, Rx.Data_In};
                        match_cnt  <= '0;
                        seed_phase <= 1'b0;
                        state      <= CHECK;
                     end
                  end
               end
               CHECK: begin
                  if (Rx.Data_Valid) begin
                     lfsr <= next_lfsr;
                     if (!byte_err) begin
                        match_cnt <= match_cnt + 1'b1;
                        if (match_cnt == MC_W'(LOCK_CNT - 1)) begin
                           state   <= LOCKED;
                           Locked  <= 1'b1;
                           bad_cnt <= '0;
                        end
                     end else begin
                        state      <= SEED;
                        seed_phase <= 1'b0;
                     end
                  end
               end
               LOCKED: begin
                  if (Rx.Data_Valid) begin
                     // free-run on our own prediction so a bad byte cannot corrupt the next
                     lfsr <= next_lfsr;
                     if (byte_err) begin
                        Err_Flag <= 1'b1;
                        if (bad_cnt == BC_W'(LOSS_CNT - 1)) begin
                           Sync_Lost  <= 1'b1;
                           Locked     <= 1'b0;
                           state      <= SEED;
                           seed_phase <= 1'b0;
                           bad_cnt    <= '0;
                        end else begin
                           bad_cnt <= bad_cnt + 1'b1;
                        end
                     end else begin
                        bad_cnt <= '0;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef PRBS_CHK_ERR_CNT_EN
   localparam int SUM_W = ((COUNT_W > 4) ? COUNT_W : 4) + 1;

   logic [3:0]       err_bits;
   logic [SUM_W-1:0] cnt_base;
   logic [SUM_W-1:0] cnt_sum;

   // clear zeroes the base first, so a same-cycle error still lands in the count
   always_comb begin
      err_bits = lock_err ? prbs9_popcount8(Rx.Data_In ^ pred_byte) : 4'd0;
      cnt_base = Clear_Count ? '0 : SUM_W'(Err_Count);
      cnt_sum  = cnt_base + SUM_W'(err_bits);
   end

   always_ff @(posedge Clk) begin
      if (RxRst) begin
         Err_Count <= '0;
      end else if (cnt_sum > SUM_W'({COUNT_W{1'b1}})) begin
         Err_Count <= '1;
      end else begin
         Err_Count <= cnt_sum[COUNT_W-1:0];
      end
   end
`else
   logic unused_cnt_inputs;
   assign unused_cnt_inputs = Clear_Count ^ lock_err;
   assign Err_Count         = '0;
`endif

endmodule

// File: doc/prbs_9_checker.md
# prbs_9_checker

Receive-side PRBS-9 pattern checker, the counterpart of the transmit-side PRBS-9 byte generator. It sits after the D-PHY receiver's byte deserializer and self-synchronizes to an incoming 8-bit PRBS-9 stream. Once locked, it compares each received byte against its local prediction and reports lock status, per-byte error flags and an accumulated bit-error count for link BER tests.

## Interface
- `LOCK_CNT`, default 4: consecutive matching bytes required to declare lock (≥1).
- `LOSS_CNT`, default 3: consecutive erroneous bytes in LOCKED that declare loss of sync (≥1).
- `COUNT_W`, default 16: width of the bit-error counter.
- `Clk` input, 1: single clock. All logic is on the rising edge.
- `RxRst` input, 1: reset, synchronous, active-high.
- `Enable` input, 1: checker run. Low forces IDLE.
- `Data_Valid` input, 1: `Data_In` carries a received byte this cycle.
- `Data_In` input, 8: received byte. Bit 7 is the earliest bit in serial order.
- `Clear_Count` input, 1: synchronous clear of `Err_Count`.
- `Locked` output, 1: checker is in LOCKED.
- `Err_Flag` output, 1: one-cycle pulse when a checked byte mismatches in LOCKED.
- `Sync_Lost` output, 1: one-cycle pulse on the LOCKED→SEED transition.
- `Err_Count` output, COUNT_W: saturating count of bit errors detected in LOCKED.

## Operation
- Polynomial x^9+x^5+1. State s[8:0]. Next bit b = s[8]^s[4], then s ← {s[7:0], b}. One byte equals 8 steps, and the first generated bit lands in bit 7.
- States are IDLE, SEED, CHECK and LOCKED.
- **IDLE**
  - `Enable`=1 → SEED.
- **SEED**
  - Capture 2 valid bytes.
  - LFSR ← {byte0[0], byte1[7:0]}, i.e. the last 9 received bits.
  - Transition → CHECK with match_cnt=0.
- **CHECK**
  - Each valid byte is compared with the predicted byte, and the LFSR advances 8 steps.
  - Match: match_cnt++. Reaching LOCK_CNT → LOCKED.
  - Mismatch: → SEED, with the seed capture restarting on the next valid byte. No error counting happens in CHECK.
- **LOCKED**
  - The LFSR advances from its own prediction, not from received data, so isolated errors do not propagate.
  - Mismatch: `Err_Flag` pulses, `Err_Count` += popcount(Data_In ^ predicted), bad_cnt++.
  - Match: bad_cnt=0.
  - bad_cnt reaching LOSS_CNT: `Sync_Lost` pulses, → SEED. Counter contents are kept.
- `Enable`=0 in any state → IDLE on the next edge. `Locked` drops; `Err_Count` holds.
- `Data_Valid`=0: no state, LFSR or counter change. Gaps between bytes are allowed anywhere.
- `Err_Count` saturates at all-ones and never wraps. The add is at least 4 bits wide before saturation.
- `Clear_Count` together with an erroring byte in the same cycle: `Err_Count` ← that byte's popcount. Clear applies first, then the add.

## Timing
- All outputs are registered. Reset values: `Locked`=0, `Err_Flag`=0, `Sync_Lost`=0, `Err_Count`=0. State = IDLE, LFSR=0, match_cnt=bad_cnt=0.
- `Err_Flag` and the `Err_Count` update appear 1 cycle after the offending `Data_Valid` cycle.
- `Locked` rises 1 cycle after the LOCK_CNT-th matching byte. With continuous valid data from SEED entry, that is the cycle after valid byte 2+LOCK_CNT.
- `Locked` falls in the same cycle that `Sync_Lost` pulses.
- `RxRst` takes priority over `Enable` and `Clear_Count`. Asserting it mid-lock gives reset values on the next edge.

## Configuration
- `PRBS_CHK_ERR_CNT_EN` defined: the popcount and `Err_Count` logic are built as described.
- Not defined:
  - `Err_Count` is tied to 0 and `Clear_Count` is ignored.
  - `Err_Flag`, `Locked` and `Sync_Lost` are unchanged.
  - No popcount logic is synthesized.

## Structure
- Package `prbs_pkg`:
  - `PRBS9_TAP_HI`=8, `PRBS9_TAP_LO`=4.
  - State enum `prbs_chk_state_t` with IDLE, SEED, CHECK, LOCKED.
  - Function `prbs9_popcount8`.
- Sub-module `prbs9_byte_step`: combinational. It takes the 9-bit state and returns the predicted byte and the next 9-bit state (8 unrolled steps). It is shared with the generator.

## Test plan
- **Lock acquire:** reset 5 cycles, `Enable`=1, feed 520 continuous generator bytes with LOCK_CNT=4 → `Locked` rises the cycle after valid byte 6; `Err_Count`=0; no `Err_Flag` through byte 520, including across the 511-bit wrap.
- **Single-bit error:** flip bit 0 of byte 100 once locked → exactly one `Err_Flag` pulse one cycle later; `Err_Count`=1; `Locked` stays 1.
- **Loss of sync:** XOR 0xFF into 3 consecutive bytes with LOSS_CNT=3 → `Err_Count`=24; `Sync_Lost` pulses on the 3rd; `Locked`=0; clean data afterwards relocks 6 valid bytes later.
- **Saturation and clear:** COUNT_W=4, invert 2 locked bytes → `Err_Count`=15 and held. `Clear_Count` in the same cycle as a byte with 2 flipped bits → `Err_Count`=2.
- **Gaps and Enable:** interleave `Data_Valid`=0 gaps during SEED, CHECK and LOCKED → same lock point in valid-byte count. Drop `Enable` while locked → `Locked`=0 next cycle; `Err_Count` retained.
- **Reset mid-operation:** assert `RxRst` while locked with a nonzero count → all outputs 0 on the next edge. Build without `PRBS_CHK_ERR_CNT_EN` → `Err_Count` stays 0 under the single-bit-error stimulus.
